// File: rtl/round_judge.sv
// round_judge: shows a pseudo-random symbol sequence for each round, then
// checks the player's presses against it in order and reports clear/fail.
module round_judge #(
  parameter int unsigned SYM_W         = 2,
  parameter int unsigned MAX_K         = 9,
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 20,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [3:0]       difficulty_k,
  input  logic [2:0]       current_round,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_code,
  output logic             show_valid,
  output logic [SYM_W-1:0] show_code,
  output logic             round_clear,
  output logic             game_fail,
  output logic             busy,
  output logic [3:0]       input_idx,
  output logic [2:0]       round_out
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned K_W    = 4;
  localparam int unsigned RND_W  = 3;

  // Tick counter sized for the longest of the three tick intervals
  localparam int unsigned TMAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
  localparam int unsigned CNT_W  = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [K_W-1:0]   MAX_K_V      = K_W'(MAX_K);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHOW_ON  = 3'd1;
  localparam logic [2:0] ST_SHOW_OFF = 3'd2;
  localparam logic [2:0] ST_INPUT    = 3'd3;
  localparam logic [2:0] ST_CLEAR    = 3'd4;
  localparam logic [2:0] ST_FAIL     = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] wl;
  logic [LFSR_W-1:0] wl_nxt;
  logic [LFSR_W-1:0] seed_r;
  logic [LFSR_W-1:0] seed_nxt;
  logic [K_W-1:0]    keff;
  logic [K_W-1:0]    keff_nxt;
  logic [K_W-1:0]    keff_c;
  logic [K_W-1:0]    sym_cnt;
  logic [K_W-1:0]    sym_cnt_nxt;
  logic [K_W-1:0]    idx_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [RND_W-1:0]  round_nxt;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Free-running LFSR; its value at start time seeds the round
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Clamp requested length to 1..MAX_K
  always_comb begin
    keff_c = difficulty_k;
    if (difficulty_k == '0) begin
      keff_c = K_W'(1);
    end else if (difficulty_k > MAX_K_V) begin
      keff_c = MAX_K_V;
    end
  end

  // Saturating increment for the tick counter
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt   = state;
    wl_nxt      = wl;
    seed_nxt    = seed_r;
    keff_nxt    = keff;
    sym_cnt_nxt = sym_cnt;
    idx_nxt     = input_idx;
    round_nxt   = round_out;
    cnt_nxt     = tick ? cnt_inc : cnt;

    case (state)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_nxt   = ST_SHOW_ON;
          seed_nxt    = lfsr;
          wl_nxt      = lfsr_step(lfsr);
          keff_nxt    = keff_c;
          round_nxt   = current_round;
          sym_cnt_nxt = K_W'(1);
          idx_nxt     = '0;
          cnt_nxt     = '0;
        end
      end

      ST_SHOW_ON: begin
        if (tick && (cnt == SHOW_LAST)) begin
          state_nxt = ST_SHOW_OFF;
          cnt_nxt   = '0;
        end
      end

      ST_SHOW_OFF: begin
        if (tick && (cnt == GAP_LAST)) begin
          cnt_nxt = '0;
          if (sym_cnt == keff) begin
            // Replay from the round seed so presses are checked in show order
            state_nxt = ST_INPUT;
            wl_nxt    = lfsr_step(seed_r);
          end else begin
            state_nxt   = ST_SHOW_ON;
            wl_nxt      = lfsr_step(wl);
            sym_cnt_nxt = sym_cnt + K_W'(1);
          end
        end
      end

      ST_INPUT: begin
        // A press takes priority over a timeout on the same cycle
        if (btn_valid) begin
          if (btn_code == wl[SYM_W-1:0]) begin
            if (input_idx == (keff - K_W'(1))) begin
              state_nxt = ST_CLEAR;
            end else begin
              idx_nxt = input_idx + K_W'(1);
              wl_nxt  = lfsr_step(wl);
              cnt_nxt = '0;
            end
          end else begin
            state_nxt = ST_FAIL;
          end
        end else if (tick && (cnt == TIMEOUT_LAST)) begin
          state_nxt = ST_FAIL;
        end
      end

      ST_CLEAR: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      wl          <= '0;
      seed_r      <= '0;
      keff        <= '0;
      sym_cnt     <= '0;
      cnt         <= '0;
      input_idx   <= '0;
      round_out   <= '0;
      show_valid  <= 1'b0;
      show_code   <= '0;
      round_clear <= 1'b0;
      game_fail   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wl          <= wl_nxt;
      seed_r      <= seed_nxt;
      keff        <= keff_nxt;
      sym_cnt     <= sym_cnt_nxt;
      cnt         <= cnt_nxt;
      input_idx   <= idx_nxt;
      round_out   <= round_nxt;
      show_valid  <= (state_nxt == ST_SHOW_ON);
      show_code   <= (state_nxt == ST_SHOW_ON) ? wl_nxt[SYM_W-1:0] : {SYM_W{1'b0}};
      round_clear <= (state_nxt == ST_CLEAR);
      game_fail   <= (state_nxt == ST_FAIL);
      busy        <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAIL);
    end
  end

endmodule

// File: doc/round_judge.md
# round_judge

Round sequencer and answer checker that drives the game-state register: for each round it shows a pseudo-random symbol sequence of length `difficulty_k`, then collects player button presses and compares them in order. It emits `round_clear` and `game_fail`, the events the game-state register consumes, and it reads back `current_round` and `difficulty_k` from that register. It sits between the button debouncer/display driver and the game-state register.

## Interface
- `SYM_W`, default 2: symbol width; there are 2^SYM_W buttons.
- `MAX_K`, default 9: maximum sequence length; larger `difficulty_k` is clamped to this.
- `SHOW_TICKS`, default 4: `tick` pulses a symbol stays lit.
- `GAP_TICKS`, default 2: `tick` pulses of blank between symbols.
- `TIMEOUT_TICKS`, default 20: `tick` pulses allowed between presses.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle slow-time enable.
- `start` in 1: one-cycle request to begin a round.
- `difficulty_k` in 4: sequence length from the game-state register.
- `current_round` in 3: round number; it is only passed through to `round_out`.
- `btn_valid` in 1: one-cycle pulse for a debounced press.
- `btn_code` in SYM_W: button id, qualified by `btn_valid`.
- `show_valid` out 1: display a symbol now.
- `show_code` out SYM_W: symbol to display while `show_valid` is high.
- `round_clear` out 1: one-cycle pulse when the round is passed.
- `game_fail` out 1: level signal, held high while in FAIL.
- `busy` out 1: high in any state other than IDLE or FAIL.
- `input_idx` out 4: number of correct presses so far in this round.
- `round_out` out 3: `current_round` registered when `start` is accepted.

## Operation
- **LFSR:** a 16-bit Fibonacci LFSR runs freely.
  - It shifts left every cycle; the new bit 0 is b15^b13^b12^b10.
  - It loads `SEED` on `rst`.
  - A symbol is the low SYM_W bits of a working LFSR after it is stepped once.
- **Sequence length:** Keff = clamp(`difficulty_k`, 1, MAX_K), latched when `start` is accepted.
- **States:** IDLE, SHOW_ON, SHOW_OFF, INPUT, CLEAR, FAIL.
- **IDLE, or FAIL, with `start`:**
  - Capture the free LFSR value into `seed_r` and copy it into the working LFSR `wl`.
  - Latch Keff and `round_out`.
  - Clear the symbol counter and `input_idx`.
  - Go to SHOW_ON.
- **SHOW_ON:**
  - On entry, step `wl`.
  - `show_valid`=1 and `show_code`=wl[SYM_W-1:0].
  - After SHOW_TICKS ticks, go to SHOW_OFF.
- **SHOW_OFF:**
  - `show_valid`=0.
  - After GAP_TICKS ticks, if Keff symbols have been shown, reload `wl`←`seed_r`, step it once, and go to INPUT. Otherwise go to SHOW_ON.
- **INPUT:** on `btn_valid`:
  - If `btn_code` equals the expected symbol and `input_idx`==Keff-1, go to CLEAR.
  - If it matches and `input_idx`<Keff-1, increment `input_idx`, step `wl`, and restart the timeout.
  - If it mismatches, go to FAIL.
  - If TIMEOUT_TICKS ticks pass with no press, go to FAIL.
- **CLEAR:** `round_clear`=1 for exactly one cycle, then go to IDLE.
- **FAIL:** `game_fail`=1. Stay until `start` (which begins a new round) or `rst`.
- **Ignored inputs:**
  - `start` is ignored while `busy`.
  - `btn_valid` is ignored outside INPUT.
- **Simultaneous events:**
  - In INPUT, a `btn_valid` wins over a timeout expiring on the same cycle.
  - `rst` wins over everything.
- **Width rules:**
  - Tick counters are wide enough for the largest of SHOW_TICKS, GAP_TICKS and TIMEOUT_TICKS, and saturate rather than wrap.
  - `input_idx` never exceeds Keff-1.

## Timing
- **Reset values:** state IDLE, free LFSR=`SEED`, and all outputs 0 (`show_code`=0, `round_out`=0).
- **Start to display:** `show_valid` rises on the cycle after `start` is accepted.
- **Tick counting:** counts begin with the first `tick` after entering a state.
- **Press latency:** a press is judged in the cycle of `btn_valid`.
  - `round_clear` or `game_fail` rises on the next cycle.
- **`round_clear`:** never high for 2 or more consecutive cycles.
- **`game_fail`:** rises from 0 once per failure, so downstream edge detection counts each failure once.
- **`rst` mid-round:** on the next edge, go to IDLE, drop `show_valid`, and emit no `round_clear` or `game_fail`.

## Test plan
- **Reset:** hold `rst` 3 cycles.
  - All outputs are 0 and `busy`=0.
  - The free LFSR equals `SEED` on the first cycle after release.
- **Correct round:**
  - Stimulus: `difficulty_k`=4, start at a known cycle N, `tick` every 4 cycles.
  - Four symbols are shown, matching a model LFSR seeded with the value at cycle N.
  - Pressing those 4 codes gives a single-cycle `round_clear`, then IDLE, with `game_fail` staying 0.
- **Wrong press:** difficulty 5, correct presses 1-2, wrong press 3.
  - `game_fail`=1 from the next cycle, `input_idx`=2, and no `round_clear`.
- **Timeout:** TIMEOUT_TICKS=20, no press in INPUT.
  - `game_fail` rises exactly one cycle after the 20th tick.
  - A press on that same tick is judged instead.
- **Clamping and ignored inputs:**
  - `difficulty_k`=0 shows 1 symbol; `difficulty_k`=15 shows 9.
  - `start` and `btn_valid` pulses during SHOW are ignored, with state and counts unchanged.
- **Reset mid-round and restart after failure:**
  - Assert `rst` during INPUT: IDLE on the next cycle, with no event pulses.
  - `start` from FAIL drops `game_fail` and begins a new show.
